// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four bytes little-endian into a 32-bit word behind a valid/ready handshake.
// Define UART_RX_OVERRUN_EN to drop words that arrive while the previous one is unconsumed and raise a sticky overrun flag.
module uart_rx_word #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        ready,
  output logic        ferr
`ifdef UART_RX_OVERRUN_EN
  ,output logic       overrun
`endif
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] E_BIT     = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] MID_START = CW'(CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t          state, next_state;
  logic            rx_meta, rxs, rxs_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_buf;
  logic            cnt_clr, sample, stop_ok, stop_bad, done;
  logic [31:0]     new_word;

  // rxs_prev gives the falling-edge detector a registered copy of the synchronized line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rxs_prev && !rxs) next_state = START;
      end
      START: begin
        if (cnt == MID_START) begin
          if (!rxs) begin
            next_state = DATA;
            cnt_clr    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == E_BIT) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) next_state = STOP;
        end
      end
      STOP: begin
        if (cnt == E_BIT) begin
          stop_ok    = rxs;
          stop_bad   = !rxs;
          next_state = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rxs) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (cnt_clr || cnt == E_BIT) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
      if (state != DATA)  bit_cnt <= 3'd0;
      else if (sample)    bit_cnt <= bit_cnt + 3'd1;
      if (sample) shift <= {rxs, shift[7:1]};
    end
  end

  assign done     = stop_ok && (byte_cnt == 2'd3);
  assign new_word = {shift, word_buf};

  // A framing error throws away the partial word so the next byte restarts at lane 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= 2'd0;
      word_buf <= 24'h0;
    end else if (stop_bad) begin
      byte_cnt <= 2'd0;
      word_buf <= 24'h0;
    end else if (stop_ok) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= shift;
        2'd1:    word_buf[15:8]  <= shift;
        2'd2:    word_buf[23:16] <= shift;
        default: word_buf        <= word_buf;
      endcase
    end
  end

`ifdef UART_RX_OVERRUN_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata   <= 32'h0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ferr <= stop_bad;
      if (done && (!valid || ready)) begin
        rdata <= new_word;
        valid <= 1'b1;
      end else begin
        if (done)           overrun <= 1'b1;
        if (valid && ready) valid   <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= 32'h0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      ferr <= stop_bad;
      if (done) begin
        rdata <= new_word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
`endif

endmodule
